// File: rtl/approx_mult_seq_ctrl.sv
// Iterative approximate multiplier: one partial-product row per clock, low k_sat
// columns OR-combined, upper columns exact. Optional macro: APPROX_MULT_EARLY_TERM_EN.
module approx_mult_seq_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned KW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a_in,
  input  logic [N-1:0]      b_in,
  input  logic [KW-1:0]     approx_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-1:0]    product,
  output logic              busy
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [KW-1:0]   r_k;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_product;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_last;
  logic [KW-1:0]   w_ksat;
  logic [W-1:0]    w_addend;
  logic [W-1:0]    w_mask;
  logic [W-1:0]    w_p;
  logic [W-1:0]    w_g;
  logic [W-1:0]    w_c;
  logic [W-1:0]    w_acc_nxt;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state == S_RUN);
  assign out_valid = r_out_valid;
  assign product   = r_product;

  assign w_ksat   = (approx_k > KW'(W)) ? KW'(W) : approx_k;
  assign w_addend = {{N{1'b0}}, r_a & {N{r_b[r_cnt]}}} << r_cnt;
  // Shifting by W clears every bit, so k_sat == 2N yields an all-ones mask.
  assign w_mask   = ~({W{1'b1}} << r_k);
  assign w_p      = r_acc ^ w_addend;
  assign w_g      = r_acc & w_addend;

  // Approximate columns emit p|g and kill the carry, so column k_sat sees carry-in 0.
  always_comb begin
    w_c       = '0;
    w_acc_nxt = '0;
    for (int unsigned j = 0; j < W; j++) begin
      if (w_mask[j]) begin
        w_acc_nxt[j] = w_p[j] | w_g[j];
        if (j < W - 1) w_c[j+1] = 1'b0;
      end else begin
        w_acc_nxt[j] = w_p[j] ^ w_c[j];
        if (j < W - 1) w_c[j+1] = w_g[j] | (w_p[j] & w_c[j]);
      end
    end
  end

`ifdef APPROX_MULT_EARLY_TERM_EN
  logic [CW:0]  w_cnt_p1;
  logic [N-1:0] w_b_hi;
  assign w_cnt_p1 = {1'b0, r_cnt} + (CW+1)'(1);
  assign w_b_hi   = r_b >> w_cnt_p1;
  assign w_last   = (w_b_hi == '0);
`else
  assign w_last   = (r_cnt == CW'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_k         <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_k   <= w_ksat;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_product   <= w_acc_nxt;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
